// File: rtl/irq_pending_ctrl.sv
// Interrupt pending/arbitration stage: latches edge/level requests per bit, masks them,
// and presents the lowest-numbered enabled source to the core until it is acknowledged.
module irq_pending_ctrl #(
    parameter int                  NrOfBits = 8,
    parameter int                  IdBits   = 3,
    parameter logic [NrOfBits-1:0] EdgeMask = '0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [NrOfBits-1:0] Req,
    input  logic [NrOfBits-1:0] Mask,
    input  logic                Ack,
    output logic                Irq,
    output logic [IdBits-1:0]   IrqId,
    output logic [NrOfBits-1:0] Pending
);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t              state_q, state_d;
    logic [NrOfBits-1:0] req_d_q;
    logic [NrOfBits-1:0] pend_q, pend_d;
    logic                irq_q, irq_d;
    logic [IdBits-1:0]   id_q, id_d;

    logic [NrOfBits-1:0] set_vec;
    logic [NrOfBits-1:0] clr_vec;
    logic [NrOfBits-1:0] enabled;
    logic [NrOfBits-1:0] id_oh;
    logic [IdBits-1:0]   winner;

    // Edge bits fire on a rising transition, level bits whenever the line is high.
    assign set_vec = (Req & ~req_d_q & EdgeMask) | (Req & ~EdgeMask);
    assign enabled = pend_q & Mask;
    assign pend_d  = (pend_q & ~clr_vec) | set_vec;

    always_comb begin
        id_oh = '0;
        for (int i = 0; i < NrOfBits; i++) begin
            if (id_q == IdBits'(i)) id_oh[i] = 1'b1;
        end
    end

    // Scan downward so the lowest enabled index is the last one written.
    always_comb begin
        winner = '0;
        for (int i = NrOfBits - 1; i >= 0; i--) begin
            if (enabled[i]) winner = IdBits'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        id_d    = id_q;
        clr_vec = '0;
        case (state_q)
            IDLE: begin
                if (|enabled) begin
                    state_d = REQ;
                    irq_d   = 1'b1;
                    id_d    = winner;
                end
            end
            REQ: begin
                if (Ack) begin
                    clr_vec = id_oh;
                    state_d = GAP;
                    irq_d   = 1'b0;
                end else if (~|(Mask & id_oh)) begin
                    state_d = IDLE;
                    irq_d   = 1'b0;
                end
            end
            GAP: begin
                state_d = IDLE;
                irq_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            req_d_q <= '0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            req_d_q <= Req;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
            id_q    <= id_d;
        end
    end

    assign Irq     = irq_q;
    assign IrqId   = id_q;
    assign Pending = pend_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Scoreboard bench for irq_pending_ctrl: directed test-plan sequences followed by random traffic,
// each cycle's expected outputs come from a behavioural model and are checked by a monitor.
module tb_irq_pending_ctrl;

    localparam int         N  = 8;
    localparam logic [7:0] EM = 8'hFE;  // bit 0 level, all others rising-edge

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] Req   = '0;
    logic [7:0] Mask  = '0;
    logic       Ack   = 1'b0;
    logic       Irq;
    logic [2:0] IrqId;
    logic [7:0] Pending;

    irq_pending_ctrl #(.NrOfBits(N), .IdBits(3), .EdgeMask(EM)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .Mask(Mask), .Ack(Ack),
        .Irq(Irq), .IrqId(IrqId), .Pending(Pending)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic       irq;
        logic [2:0] id;
        logic [7:0] pend;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model: pending set as a bit array, the interrupt as "serving source m_id",
    // and a cooldown counter for the quiet cycle after an acknowledge.
    bit  m_pend[N];
    bit  m_prev[N];
    bit  m_serving;
    int  m_id;
    int  m_cool;

    task automatic model_step(input bit rst, input bit [7:0] req, input bit [7:0] mask, input bit ack);
        bit nxt[N];
        int pick;
        if (rst) begin
            for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_prev[i] = 0; end
            m_serving = 0; m_id = 0; m_cool = 0;
            return;
        end
        for (int i = 0; i < N; i++) nxt[i] = m_pend[i];
        if (m_serving && ack) nxt[m_id] = 0;
        for (int i = 0; i < N; i++) begin
            if (EM[i] ? (req[i] && !m_prev[i]) : req[i]) nxt[i] = 1;
        end
        if (m_serving) begin
            if (ack) begin m_serving = 0; m_cool = 1; end
            else if (!mask[m_id]) m_serving = 0;
        end else if (m_cool > 0) begin
            m_cool = m_cool - 1;
        end else begin
            pick = -1;
            for (int i = 0; i < N; i++) if (pick < 0 && m_pend[i] && mask[i]) pick = i;
            if (pick >= 0) begin m_serving = 1; m_id = pick; end
        end
        for (int i = 0; i < N; i++) begin m_pend[i] = nxt[i]; m_prev[i] = req[i]; end
    endtask

    task automatic drive(input bit rst, input bit [7:0] req, input bit [7:0] mask, input bit ack,
                         input string tag);
        exp_t e;
        @(negedge Clock);
        Reset = rst; Req = req; Mask = mask; Ack = ack;
        model_step(rst, req, mask, ack);
        e.irq = m_serving;
        e.id  = m_serving ? 3'(m_id) : 3'(m_id);
        for (int i = 0; i < N; i++) e.pend[i] = m_pend[i];
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are registered, so every edge presents one response to check.
    always @(posedge Clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (Irq !== e.irq) begin
                failures++;
                $display("FAIL %s irq: got %b want %b @%0t", e.tag, Irq, e.irq, $time);
            end
            checks++;
            if (Pending !== e.pend) begin
                failures++;
                $display("FAIL %s pending: got %h want %h @%0t", e.tag, Pending, e.pend, $time);
            end
            if (e.irq) begin
                checks++;
                if (IrqId !== e.id) begin
                    failures++;
                    $display("FAIL %s irqid: got %0d want %0d @%0t", e.tag, IrqId, e.id, $time);
                end
            end
        end
    end

    initial begin
        bit [7:0] r, mk;
        bit       a, rs;

        repeat (2) drive(1, 8'h00, 8'hFF, 0, "reset");

        // Single edge pulse on bit 3, then acknowledge.
        drive(0, 8'h08, 8'hFF, 0, "pulse3");
        drive(0, 8'h00, 8'hFF, 0, "pulse3_lat");
        drive(0, 8'h00, 8'hFF, 0, "pulse3_irq");
        drive(0, 8'h00, 8'hFF, 1, "pulse3_ack");
        repeat (3) drive(0, 8'h00, 8'hFF, 0, "pulse3_quiet");

        // Two simultaneous edges: bit 2 served before bit 5.
        drive(0, 8'h24, 8'hFF, 0, "dual");
        repeat (2) drive(0, 8'h00, 8'hFF, 0, "dual_wait");
        drive(0, 8'h00, 8'hFF, 1, "dual_ack2");
        repeat (3) drive(0, 8'h00, 8'hFF, 0, "dual_gap");
        drive(0, 8'h00, 8'hFF, 1, "dual_ack5");
        repeat (2) drive(0, 8'h00, 8'hFF, 0, "dual_done");

        // Level bit 0 held high re-pends through ack.
        repeat (3) drive(0, 8'h01, 8'hFF, 0, "level");
        drive(0, 8'h01, 8'hFF, 1, "level_ack");
        repeat (3) drive(0, 8'h01, 8'hFF, 0, "level_repend");
        drive(0, 8'h00, 8'hFF, 1, "level_drop_ack");
        repeat (3) drive(0, 8'h00, 8'hFF, 0, "level_idle");

        // Masked pend, then unmask, withdraw, unmask again, ack with mask clear.
        drive(0, 8'h10, 8'h00, 0, "masked");
        repeat (2) drive(0, 8'h00, 8'h00, 0, "masked_hold");
        drive(0, 8'h00, 8'h10, 0, "unmask");
        drive(0, 8'h00, 8'h10, 0, "unmask_irq");
        drive(0, 8'h00, 8'h00, 0, "withdraw");
        drive(0, 8'h00, 8'h00, 0, "withdraw_after");
        drive(0, 8'h00, 8'h10, 0, "remask");
        drive(0, 8'h00, 8'h10, 0, "remask_irq");
        drive(0, 8'h00, 8'h00, 1, "ack_and_unmask");
        repeat (2) drive(0, 8'h00, 8'hFF, 0, "ack_and_unmask_after");

        // Reset while serving with an edge bit held high.
        drive(0, 8'h02, 8'hFF, 0, "rst_req");
        repeat (2) drive(0, 8'h02, 8'hFF, 0, "rst_irq");
        drive(1, 8'h02, 8'hFF, 0, "rst_mid");
        drive(0, 8'h02, 8'hFF, 0, "rst_repend");
        drive(0, 8'h02, 8'hFF, 0, "rst_reirq");
        drive(0, 8'h00, 8'hFF, 1, "rst_ack");
        repeat (2) drive(0, 8'h00, 8'hFF, 0, "rst_idle");

        // Ack in IDLE does nothing.
        drive(0, 8'h00, 8'hFF, 1, "idle_ack");
        drive(0, 8'h00, 8'hFF, 0, "idle_ack_after");

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            r  = ($urandom_range(0, 3) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00;
            mk = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFF;
            a  = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 99) == 0);
            drive(rs, r, mk, a, "random");
        end

        repeat (3) @(negedge Clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d left want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
